rv32_wb_arbiter: RTL and testbench
==================================

RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning the number of writeback requesters (2..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, NUM_REQ, per-requester writeback valid.
REQ-005 SHALL have port req_rd, input, NUM_REQ x 5, per-requester destination register id.
REQ-006 SHALL have port req_data, input, NUM_REQ x 32, per-requester writeback word.
REQ-007 SHALL have port req_ready, output, NUM_REQ, per-requester grant; transfer occurs when valid and ready are both 1 in the same cycle.
REQ-008 SHALL have port hold, input, 1, freeze: no grants and the output register holds.
REQ-009 SHALL have port rsv_valid, input, 1, issue-stage reservation strobe.
REQ-010 SHALL have port rsv_rd, input, 5, register reserved by the issue stage.
REQ-011 SHALL have port rf_write, output, 1, register-file write enable.
REQ-012 SHALL have port rf_rw, output, 5, register-file write address.
REQ-013 SHALL have port rf_d, output, 32, register-file write data.
REQ-014 SHALL have port busy, output, 32, per-register pending-write scoreboard; bit 0 is always 0.

Function
REQ-015 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid=1.
REQ-016 SHALL assert no req_ready bit while hold=1.
REQ-017 SHALL register the granted request: rf_write/rf_rw/rf_d reflect the grant exactly one cycle after the handshake (latency 1).
REQ-018 SHALL drive rf_write=0 in any cycle following a cycle with no grant; rf_rw/rf_d then retain their last values.
REQ-019 SHALL keep rf_write/rf_rw/rf_d unchanged while hold=1, including a pending rf_write=1.
REQ-020 SHALL accept a request with req_rd=0 (ready asserted per arbitration) but produce rf_write=0 for it.
REQ-021 SHALL set busy[rsv_rd] on posedge clk when rsv_valid=1 and rsv_rd!=0; rsv_rd=0 is ignored.
REQ-022 SHALL clear busy[rf_rw] on the posedge where rf_write=1 and hold=0 (write retired).
REQ-023 SHALL leave busy[n]=1 when a reservation and a retirement of register n coincide (reservation wins).
REQ-024 SHALL not modify busy for requester writes to registers that were not reserved beyond REQ-022 (clearing an already-clear bit is a no-op).
REQ-025 SHALL make the arbitration decision combinationally from req_valid and arbitration state in the same cycle.

Reset
REQ-026 SHALL on rstn=0, immediately and independently of clk, force rf_write=0, rf_rw=0, rf_d=0, busy=0, req_ready=0, and reset the round-robin pointer to 0.
REQ-027 SHALL discard any in-flight registered write when reset asserts mid-operation; no write appears after release.
REQ-028 SHALL resume arbitration on the first posedge clk after rstn deasserts.

Configuration
REQ-029 SHALL, with RV32_WB_ARB_RR_EN defined, arbitrate round-robin: the search starts at the index after the last granted requester, wrapping from NUM_REQ-1 to 0; the pointer advances only on a grant.
REQ-030 SHALL, without RV32_WB_ARB_RR_EN, arbitrate fixed-priority: the lowest-index valid requester wins; no pointer state exists.

Verification
REQ-031 SHALL cover: req_valid=001, req_rd[0]=5, data 0xDEADBEEF -> ready=001 same cycle; next cycle rf_write=1, rf_rw=5, rf_d=0xDEADBEEF; following cycle rf_write=0.
REQ-032 SHALL cover: all three valid for 6 cycles -> RR defined: grants 0,1,2,0,1,2; RR undefined: grant 0 every cycle.
REQ-033 SHALL cover: rsv_valid=1, rsv_rd=7 -> busy[7]=1 next cycle; later a write to x7 retires -> busy[7]=0 the cycle after rf_write=1.
REQ-034 SHALL cover: reservation of x9 in the same cycle as a retiring write to x9 -> busy[9] remains 1.
REQ-035 SHALL cover: write to x0 with data 0x1 -> ready asserted, rf_write stays 0, busy[0] stays 0; rsv_rd=0 -> busy unchanged.
REQ-036 SHALL cover: pending rf_write=1 (x3), hold=1 for 2 cycles -> outputs frozen and ready=0; rstn pulsed low mid-hold -> rf_write=0, busy=0 immediately.

Source files
------------

// File: rtl/rv32_wb_arbiter.sv
// Writeback arbiter: grants one of NUM_REQ writeback requesters per cycle into a registered
// register-file write port and tracks pending writes. Define RV32_WB_ARB_RR_EN for round-robin, else fixed priority.
module rv32_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    hold,
  input  logic                    rsv_valid,
  input  logic [4:0]              rsv_rd,
  output logic                    rf_write,
  output logic [4:0]              rf_rw,
  output logic [31:0]             rf_d,
  output logic [31:0]             busy
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [RW-1:0]      sel_rd;
  logic [DW-1:0]      sel_data;
  logic [31:0]        busy_nxt;

`ifdef RV32_WB_ARB_RR_EN
  localparam int unsigned IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] idx;
`endif

  // Grant selection; suppressed during hold and while reset is asserted
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
`ifdef RV32_WB_ARB_RR_EN
    gnt_idx  = '0;
    idx      = '0;
    if (rstn && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = IW'((int'(ptr) + k) % int'(NUM_REQ));
        if (!gnt_any && req_valid[idx]) begin
          gnt[idx] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
`else
    if (rstn && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && req_valid[k]) begin
          gnt[k]  = 1'b1;
          gnt_any = 1'b1;
        end
      end
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_rd   = req_rd[k*RW +: RW];
        sel_data = req_data[k*DW +: DW];
      end
    end
  end

  assign req_ready = gnt;

  // Scoreboard update: retirement first so a coincident reservation wins
  always_comb begin
    busy_nxt = busy;
    if (rf_write && !hold) begin
      busy_nxt[rf_rw] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != '0)) begin
      busy_nxt[rsv_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_write <= 1'b0;
      rf_rw    <= '0;
      rf_d     <= '0;
      busy     <= '0;
    end else begin
      if (!hold) begin
        rf_write <= gnt_any && (sel_rd != '0);
        if (gnt_any) begin
          rf_rw <= sel_rd;
          rf_d  <= sel_data;
        end
      end
      busy <= busy_nxt;
    end
  end

`ifdef RV32_WB_ARB_RR_EN
  // Pointer holds the index where the next search starts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed self-checking bench for rv32_wb_arbiter (expectations follow RV32_WB_ARB_RR_EN if defined).
module tb_rv32_wb_arbiter;

  localparam int unsigned NUM_REQ = 3;

  logic                  clk;
  logic                  rstn;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*5-1:0]  req_rd;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  hold;
  logic                  rsv_valid;
  logic [4:0]            rsv_rd;
  logic                  rf_write;
  logic [4:0]            rf_rw;
  logic [31:0]           rf_d;
  logic [31:0]           busy;

  int checks = 0;
  int errors = 0;

  rv32_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .hold(hold), .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .rf_write(rf_write), .rf_rw(rf_rw), .rf_d(rf_d), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; hold = 1'b0; rsv_valid = 1'b0; rsv_rd = '0;
    req_valid = '1; req_rd = '0; req_data = '0;
    #3;
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++;
    if (rf_write !== 1'b0 || rf_rw !== 5'd0 || rf_d !== 32'd0 || busy !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got=%b/%0d/%h/%h exp=0/0/0/0", rf_write, rf_rw, rf_d, busy);
    end
    req_valid = '0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req_valid = 3'b001; req_rd[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (rf_write !== 1'b1 || rf_rw !== 5'd5 || rf_d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", rf_write, rf_rw, rf_d);
    end
    tick();
    checks++;
    if (rf_write !== 1'b0 || rf_rw !== 5'd5 || rf_d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_idle got=%b/%0d/%h exp=0/5/deadbeef", rf_write, rf_rw, rf_d);
    end
  endtask

  task automatic test_arbitration();
    int exp_idx;
    pulse_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_rd[k*5 +: 5]    = 5'(k + 1);
      req_data[k*32 +: 32] = 32'h100 + 32'(k);
    end
    req_valid = 3'b111;
    #1;
    for (int i = 0; i < 6; i++) begin
`ifdef RV32_WB_ARB_RR_EN
      exp_idx = i % 3;
`else
      exp_idx = 0;
`endif
      checks++;
      if (req_ready !== 3'(1 << exp_idx)) begin
        errors++; $display("FAIL arb_grant cycle=%0d got=%b exp=%b", i, req_ready, 3'(1 << exp_idx));
      end
      tick();
      checks++;
      if (rf_write !== 1'b1 || rf_rw !== 5'(exp_idx + 1) || rf_d !== 32'h100 + 32'(exp_idx)) begin
        errors++; $display("FAIL arb_write cycle=%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_write, rf_rw, rf_d,
                           exp_idx + 1, 32'h100 + 32'(exp_idx));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_busy();
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    tick();
    rsv_valid = 1'b0;
    checks++;
    if (busy !== 32'h0000_0080) begin errors++; $display("FAIL busy_set got=%h exp=00000080", busy); end
    req_valid = 3'b001; req_rd[4:0] = 5'd7; req_data[31:0] = 32'h77;
    tick();
    req_valid = '0;
    checks++;
    if (rf_write !== 1'b1 || rf_rw !== 5'd7 || busy !== 32'h0000_0080) begin
      errors++; $display("FAIL busy_pending got=%b/%0d/%h exp=1/7/00000080", rf_write, rf_rw, busy);
    end
    tick();
    checks++;
    if (busy !== 32'd0 || rf_write !== 1'b0) begin
      errors++; $display("FAIL busy_retire got=%h/%b exp=00000000/0", busy, rf_write);
    end
  endtask

  task automatic test_collision();
    rsv_valid = 1'b1; rsv_rd = 5'd9;
    tick();
    rsv_valid = 1'b0;
    req_valid = 3'b001; req_rd[4:0] = 5'd9; req_data[31:0] = 32'h99;
    tick();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_rd = 5'd9;
    checks++;
    if (rf_write !== 1'b1 || rf_rw !== 5'd9) begin
      errors++; $display("FAIL collide_write got=%b/%0d exp=1/9", rf_write, rf_rw);
    end
    tick();
    rsv_valid = 1'b0;
    checks++;
    if (busy !== 32'h0000_0200) begin errors++; $display("FAIL collide_busy got=%h exp=00000200", busy); end
  endtask

  task automatic test_x0();
    req_valid = 3'b001; req_rd[4:0] = 5'd0; req_data[31:0] = 32'h1;
    rsv_valid = 1'b1; rsv_rd = 5'd0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0; rsv_valid = 1'b0;
    checks++;
    if (rf_write !== 1'b0) begin errors++; $display("FAIL x0_write got=%b exp=0", rf_write); end
    checks++;
    if (busy !== 32'h0000_0200) begin errors++; $display("FAIL x0_busy got=%h exp=00000200", busy); end
  endtask

  task automatic test_hold_reset();
    req_valid = 3'b001; req_rd[4:0] = 5'd3; req_data[31:0] = 32'h33;
    rsv_valid = 1'b1; rsv_rd = 5'd3;
    tick();
    rsv_valid = 1'b0;
    hold = 1'b1; req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready got=%b exp=000", req_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rf_write !== 1'b1 || rf_rw !== 5'd3 || rf_d !== 32'h33 || req_ready !== 3'b000 || busy !== 32'h0000_0208) begin
        errors++; $display("FAIL hold_frozen cycle=%0d got=%b/%0d/%h/%b/%h exp=1/3/33/000/00000208",
                           i, rf_write, rf_rw, rf_d, req_ready, busy);
      end
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (rf_write !== 1'b0 || rf_rw !== 5'd0 || rf_d !== 32'd0 || busy !== 32'd0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL hold_reset got=%b/%0d/%h/%h/%b exp=0/0/0/0/000", rf_write, rf_rw, rf_d, busy, req_ready);
    end
    hold = 1'b0; req_valid = '0;
    #1;
    rstn = 1'b1;
    tick();
    checks++;
    if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_discard got=%b exp=0", rf_write); end
    req_valid = 3'b010; req_rd[9:5] = 5'd12; req_data[63:32] = 32'hCAFE0012;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL resume_ready got=%b exp=010", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (rf_write !== 1'b1 || rf_rw !== 5'd12 || rf_d !== 32'hCAFE0012) begin
      errors++; $display("FAIL resume_write got=%b/%0d/%h exp=1/12/cafe0012", rf_write, rf_rw, rf_d);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_busy();
    test_collision();
    test_x0();
    test_hold_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
